// File: rtl/seq_mlp_layer.sv
// Time-multiplexed dense layer: one MAC walks the NOUT x NIN weight matrix, then bias/saturate per neuron.
// Optional ReLU on the written outputs when SEQ_MLP_RELU_EN is defined.
module seq_mlp_layer #(
    parameter int WIDTH = 16,
    parameter int NIN   = 2,
    parameter int NOUT  = 2,
    parameter int FRAC  = 0,
    parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0,
    parameter logic [WIDTH*NOUT-1:0]     BIAS_FLAT           = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [0:NIN-1][WIDTH-1:0]    in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [0:NOUT-1][WIDTH-1:0]   out
);
    localparam int AW = 2*WIDTH + $clog2(NIN) + 1;
    localparam int RW = AW + 1;
    localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int JW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam logic signed [RW-1:0] SMAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SMIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;
    state_t state, state_nxt;

    logic signed [WIDTH-1:0] wmem [NOUT][NIN];
    logic signed [WIDTH-1:0] bmem [NOUT];
    logic signed [WIDTH-1:0] x_reg [NIN];
    logic signed [AW-1:0]    acc, acc_sh;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [RW-1:0]    r;
    logic signed [WIDTH-1:0] res_sat, res;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic last_j, last_i;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_row
            assign bmem[gi] = BIAS_FLAT[(NOUT-1-gi)*WIDTH +: WIDTH];
            for (gj = 0; gj < NIN; gj++) begin : g_col
                assign wmem[gi][gj] = WEIGHTS_MATRIX_FLAT[(NIN*NOUT-(gi*NIN+gj))*WIDTH-1 -: WIDTH];
            end
        end
    endgenerate

    assign last_j = (j == JW'(NIN-1));
    assign last_i = (i == IW'(NOUT-1));
    assign prod   = x_reg[j] * wmem[i][j];
    assign acc_sh = acc >>> FRAC;
    assign r      = RW'(acc_sh) + RW'(bmem[i]);

    always_comb begin
        res_sat = r[WIDTH-1:0];
        if (r > SMAX)      res_sat = SMAX[WIDTH-1:0];
        else if (r < SMIN) res_sat = SMIN[WIDTH-1:0];
`ifdef SEQ_MLP_RELU_EN
        res = res_sat[WIDTH-1] ? '0 : res_sat;
`else
        res = res_sat;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC:  if (last_j) state_nxt = FIN;
            FIN:  state_nxt = last_i ? DONE : MAC;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            i   <= '0;
            j   <= '0;
            out <= '0;
            for (int k = 0; k < NIN; k++) x_reg[k] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int k = 0; k < NIN; k++) x_reg[k] <= in[k];
                    acc <= '0;
                    i   <= '0;
                    j   <= '0;
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    if (!last_j) j <= j + 1'b1;
                end
                FIN: begin
                    out[i] <= res;
                    acc    <= '0;
                    if (!last_i) begin
                        i <= i + 1'b1;
                        j <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mlp_layer.sv
// Directed bench for seq_mlp_layer (2x2, weights {2,-3,-1,4}, bias {5,-6}).
module tb_seq_mlp_layer;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic signed [0:1][15:0] in_v;
    logic signed [0:1][15:0] out_v;
    int checks = 0, failures = 0;
    int lat, seen, bad;

    localparam logic [63:0] W = {16'd2, 16'hFFFD, 16'hFFFF, 16'd4};
    localparam logic [31:0] B = {16'd5, 16'hFFFA};

    seq_mlp_layer #(.WIDTH(16), .NIN(2), .NOUT(2), .FRAC(0),
                    .WEIGHTS_MATRIX_FLAT(W), .BIAS_FLAT(B)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in(in_v), .out_valid(out_valid), .out_ready(out_ready), .out(out_v));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int o(input int k);
        return int'($signed(out_v[k]));
    endfunction

    // Accept one vector and return edges from accept to out_valid (-1 on timeout).
    task automatic run_vec(input int a, input int b, output int l);
        @(posedge clk); #1;
        in_v[0] = 16'(a); in_v[1] = 16'(b); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_v[0] = 16'h7777; in_v[1] = 16'h1234;
        chk("in_ready_drop", int'(in_ready), 0);
        l = -1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin l = c; break; end
        end
    endtask

    task automatic handshake_done();
        @(posedge clk); #1;
        chk("hs_out_valid", int'(out_valid), 0);
        chk("hs_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_v = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out0", o(0), 0);
        chk("rst_out1", o(1), 0);
        rst_n = 1'b1;

        run_vec(10, 1, lat);
        chk("basic_lat", lat, 6);
        chk("basic_out0", o(0), 22);
`ifdef SEQ_MLP_RELU_EN
        chk("basic_out1", o(1), 0);
`else
        chk("basic_out1", o(1), -12);
`endif
        handshake_done();

        run_vec(30000, 0, lat);
        chk("sat_lat", lat, 6);
        chk("sat_out0", o(0), 32767);
`ifdef SEQ_MLP_RELU_EN
        chk("sat_out1", o(1), 0);
`else
        chk("sat_out1", o(1), -30006);
`endif
        handshake_done();

        run_vec(-30000, -30000, lat);
        chk("nsat_lat", lat, 6);
        chk("nsat_out0", o(0), 30005);
`ifdef SEQ_MLP_RELU_EN
        chk("nsat_out1", o(1), 0);
`else
        chk("nsat_out1", o(1), -32768);
`endif
        handshake_done();

        out_ready = 1'b0;
        run_vec(10, 1, lat);
        chk("bp_lat", lat, 6);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin in_v[0] = 16'd30000; in_v[1] = 16'd0; in_valid = 1'b1; end
            if (c == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            if (!out_valid || in_ready || o(0) != 22) bad++;
`ifdef SEQ_MLP_RELU_EN
            if (o(1) != 0) bad++;
`else
            if (o(1) != -12) bad++;
`endif
        end
        chk("bp_stable", bad, 0);
        out_ready = 1'b1;
        handshake_done();
        chk("bp_out0_kept", o(0), 22);

        run_vec(30000, 0, lat);
        handshake_done();
        @(posedge clk); #1;
        in_v[0] = 16'd30000; in_v[1] = 16'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mrst_no_valid", seen, 0);
        chk("mrst_out0", o(0), 0);
        chk("mrst_out1", o(1), 0);
        chk("mrst_in_ready", int'(in_ready), 1);

        run_vec(10, 1, lat);
        chk("post_lat", lat, 6);
        chk("post_out0", o(0), 22);
`ifdef SEQ_MLP_RELU_EN
        chk("post_out1", o(1), 0);
`else
        chk("post_out1", o(1), -12);
`endif
        handshake_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mlp_layer.md
# seq_mlp_layer

Time-multiplexed fully-connected layer with optional ReLU, the sequential successor to the combinational dense layers used in the `nonlinearNet` stack. It holds an `NOUT x NIN` signed weight matrix and bias vector as parameters, with the same flat packing as the existing layers. It computes all outputs with a single multiply-accumulate unit over `NOUT*(NIN+1)` cycles, so deep or wide networks can be built by chaining layers through valid/ready handshakes instead of instantiating `NIN*NOUT` multipliers.

## Interface
- `WIDTH`, 16: signed data, weight and bias width.
- `NIN`, 2: input vector length, ≥1.
- `NOUT`, 2: output vector length (neurons), ≥1.
- `FRAC`, 0: arithmetic right shift applied to the dot product before bias add (fixed-point scaling).
- `WEIGHTS_MATRIX_FLAT`, 0: `WIDTH*NIN*NOUT` bits. Weight `[i][j]` is at `[(NIN*NOUT-(i*NIN+j))*WIDTH-1 -: WIDTH]`, so row 0 col 0 is in the MSBs.
- `BIAS_FLAT`, 0: `WIDTH*NOUT` bits. Bias `[i]` is at `[(NOUT-1-i)*WIDTH +: WIDTH]`.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: input vector valid.
- `in_ready` output 1: layer can accept a vector.
- `in` input `signed [WIDTH-1:0] [0:NIN-1]`: input vector.
- `out_valid` output 1: output vector valid.
- `out_ready` input 1: downstream accepts output.
- `out` output `signed [WIDTH-1:0] [0:NOUT-1]`: registered output vector.

## Operation
- Reset (`rst_n`=0 at a clock edge) has the following effects:
  - State goes to IDLE.
  - `in_ready`=1, `out_valid`=0.
  - All `out[i]`=0.
  - Accumulator and neuron/column counters are cleared.
- **IDLE**:
  - `in_ready`=1.
  - When `in_valid` is high, the inputs are latched into an internal register, `i`=0, `j`=0, acc=0, and the state goes to MAC.
- **MAC**:
  - `in_ready`=0.
  - Each cycle: acc += `w[i][j]*x[j]`, using a full `2*WIDTH` signed product.
  - The accumulator width is `2*WIDTH+$clog2(NIN)+1`, so it never wraps.
  - When `j==NIN-1`, the state goes to FIN. Otherwise `j++`.
- **FIN** (one cycle):
  - Compute r = (acc >>> FRAC) + sign-extended `b[i]`. The shift is a floor (truncating) arithmetic shift.
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Apply the activation (see Configuration).
  - Write the result to `out[i]` and clear acc.
  - If `i==NOUT-1`, go to DONE. Otherwise `i++`, `j`=0, go to MAC.
- **DONE**:
  - `out_valid`=1.
  - `out` is held stable until `out_valid && out_ready`; then go to IDLE on the next edge.
- `out[i]` entries already written keep their previous-vector values until overwritten. `out` is only meaningful while `out_valid`=1.
- `in` is sampled only on the accept edge. Changes afterwards do not affect the result.

## Timing
- Accept edge to `out_valid` rising: exactly `NOUT*(NIN+1)` cycles. This is 6 for the default 2x2.
- `in_ready` drops the cycle after accept and rises the cycle after the output handshake.
- Minimum vector period: `NOUT*(NIN+1)+2` cycles with `out_ready` tied high.
- `out_ready` asserted before `out_valid` has no effect.
- `in_valid` during MAC, FIN or DONE is ignored. There is no queuing, so upstream must hold `in_valid` until `in_ready`.
- Reset mid-operation (any state) takes effect on that edge and discards the partial result.
- `rst_n` dominates `in_valid` and `out_ready` on the same edge.

## Configuration
- `SEQ_MLP_RELU_EN` defined: FIN applies ReLU after saturation, so negative results are written as 0.
- `SEQ_MLP_RELU_EN` undefined: FIN writes the saturated linear value; the block is a pure affine layer.
- Latency is identical in both builds.

## Test plan
All scenarios use WIDTH=16, NIN=2, NOUT=2, FRAC=0, weights {2,-3,-1,4} (row-major), bias {5,-6}.
- **Reset:** hold `rst_n`=0 for 3 cycles → `in_ready`=1, `out_valid`=0, `out`={0,0}.
- **Basic:** `in`={10,1}, `out_ready`=1 → `out_valid` exactly 6 cycles after accept.
  - RELU_EN: `out`={22,0}.
  - Without: `out`={22,-12}.
- **Saturation:** `in`={30000,0} → `out[0]`=32767.
  - `out[1]` is 0 with RELU_EN, -30006 without.
- **Negative saturation:** `in`={-30000,-30000}, ReLU off → `out`={30005,-32768}.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out` stays stable and `in_ready`=0, and an `in_valid` pulse during this time is ignored.
  - Then pulse `out_ready` → IDLE next cycle.
- **Mid-operation reset:** assert `rst_n`=0 at cycle 3 of a computation → `out_valid` never rises and `out`={0,0}.
  - The next vector `in`={10,1} produces the Basic result.
